// File: rtl/alu_seq.sv
// Sequential ALU: handshaked single-cycle ops plus iterative shift and multiply.
// Define ALU_SAT_EN to make ADD/SUB/MUL saturate instead of wrapping.
module alu_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [3:0]   OP,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [W-1:0] Out,
    output logic         EQ,
    output logic         LT
);
    localparam int NW = CW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_XALL = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_GBI  = 4'd9;
    localparam logic [3:0] OP_SB0  = 4'd10;
    localparam logic [3:0] OP_SB1  = 4'd11;
    localparam logic [3:0] OP_MV   = 4'd12;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t        state_q;
    logic [3:0]    op_q;
    logic [W-1:0]  a_q, b_q, acc_q, out_q;
    logic [NW-1:0] cnt_q;
    logic          eq_q, lt_q;

    logic [CW-1:0] idx;
    logic [W-1:0]  mask, res, sum, dif;
    logic [W-1:0]  addend, mac, mul_res, sh;

    assign idx = InputB[CW-1:0];
    assign mask = {{(W-1){1'b0}}, 1'b1} << idx;
    assign addend = b_q[0] ? a_q : {W{1'b0}};
    assign sh = (op_q == OP_SLL) ? (a_q << 1) : (a_q >> 1);

`ifdef ALU_SAT_EN
    logic sum_c, dif_b, mac_c, ovf_q, ahi_q, mul_ovf;
    assign {sum_c, sum} = {1'b0, InputA} + {1'b0, InputB};
    assign {dif_b, dif} = {1'b0, InputB} - {1'b0, InputA};
    assign {mac_c, mac} = {1'b0, acc_q} + {1'b0, addend};
    // ahi_q: a_q has shifted out a 1, so any further add overflows
    assign mul_ovf = ovf_q | (b_q[0] & (mac_c | ahi_q));
    assign mul_res = mul_ovf ? {W{1'b1}} : mac;
`else
    assign sum = InputA + InputB;
    assign dif = InputB - InputA;
    assign mac = acc_q + addend;
    assign mul_res = mac;
`endif

    always_comb begin
        res = '0;
        case (OP)
`ifdef ALU_SAT_EN
            OP_ADD:  res = sum_c ? {W{1'b1}} : sum;
            OP_SUB:  res = dif_b ? {W{1'b0}} : dif;
`else
            OP_ADD:  res = sum;
            OP_SUB:  res = dif;
`endif
            OP_AND:  res = InputA & InputB;
            OP_XOR:  res = InputA ^ InputB;
            OP_SLL:  res = InputA << idx;
            OP_SRL:  res = InputA >> idx;
            OP_XALL: res = {{(W-1){1'b0}}, ^InputB};
            OP_GBI:  res = {{(W-1){1'b0}}, InputA[idx]};
            OP_SB0:  res = InputA & ~mask;
            OP_SB1:  res = InputA | mask;
            OP_MV:   res = InputA;
            default: res = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifdef ALU_SAT_EN
            ovf_q   <= 1'b0;
            ahi_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (In_valid) begin
                    op_q  <= OP;
                    a_q   <= InputA;
                    b_q   <= InputB;
                    acc_q <= '0;
`ifdef ALU_SAT_EN
                    ovf_q <= 1'b0;
                    ahi_q <= 1'b0;
`endif
                    if (OP == OP_MUL) begin
                        cnt_q   <= NW'(W);
                        state_q <= ITER;
                    end else if ((OP == OP_SLL || OP == OP_SRL) && idx != '0) begin
                        cnt_q   <= {1'b0, idx};
                        state_q <= ITER;
                    end else begin
                        out_q   <= res;
                        state_q <= DONE;
                        if (OP == OP_CMP) begin
                            eq_q <= (InputA == InputB);
                            lt_q <= (InputA < InputB);
                        end
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_q <= mac;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
`ifdef ALU_SAT_EN
                        ovf_q <= mul_ovf;
                        ahi_q <= ahi_q | a_q[W-1];
`endif
                        if (cnt_q == NW'(1)) out_q <= mul_res;
                    end else begin
                        a_q <= sh;
                        if (cnt_q == NW'(1)) out_q <= sh;
                    end
                    if (cnt_q == NW'(1)) state_q <= DONE;
                end
                DONE: if (Out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign In_ready  = (state_q == IDLE);
    assign Out_valid = (state_q == DONE);
    assign Out       = out_q;
    assign EQ        = eq_q;
    assign LT        = lt_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (W=8), hand-computed expectations.
// Honours ALU_SAT_EN for the saturating arithmetic vectors.
module tb_alu_seq;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       In_valid, In_ready;
    logic [3:0] OP;
    logic [7:0] InputA, InputB;
    logic       Out_valid, Out_ready;
    logic [7:0] Out;
    logic       EQ, LT;

    int n_chk = 0;
    int n_err = 0;

    alu_seq #(.W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .In_valid(In_valid), .In_ready(In_ready),
        .OP(OP), .InputA(InputA), .InputB(InputB),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out(Out), .EQ(EQ), .LT(LT)
    );

    always #5 Clk = ~Clk;

`ifdef ALU_SAT_EN
    localparam logic [7:0] E_MUL20 = 8'd255;
    localparam logic [7:0] E_SUB   = 8'd0;
    localparam logic [7:0] E_ADD   = 8'd255;
`else
    localparam logic [7:0] E_MUL20 = 8'd144;
    localparam logic [7:0] E_SUB   = 8'd249;
    localparam logic [7:0] E_ADD   = 8'd44;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic take();
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] a, b,
                       output logic [7:0] res, output int lat,
                       output logic rdy_seen);
        OP = op; InputA = a; InputB = b; In_valid = 1'b1;
        tick();
        In_valid = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (!Out_valid && lat < 50) begin
            rdy_seen |= In_ready;
            tick();
            lat++;
        end
        res = Out;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [7:0] a, b, exp, input int exp_lat);
        logic [7:0] r;
        int         l;
        logic       rs;
        run(op, a, b, r, l, rs);
        check(tag, r, exp);
        check({tag, "_lat"}, l, exp_lat);
        take();
        check({tag, "_idle"}, Out_valid, 0);
    endtask

    initial begin
        logic [7:0] r;
        int         l;
        logic       rs;
        Reset_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
        OP = '0; InputA = '0; InputB = '0;
        #12;
        check("rst_out", Out, 0);
        check("rst_vld", Out_valid, 0);
        check("rst_eq", EQ, 0);
        check("rst_lt", LT, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        check("rst_rdy", In_ready, 1);

        do_op("add", 4'd0, 8'd3, 8'd4, 8'd7, 0);

        run(4'd6, 8'd13, 8'd11, r, l, rs);
        check("mul", r, 143);
        check("mul_lat", l, 8);
        check("mul_busy_rdy", rs, 0);
        check("mul_done_rdy", In_ready, 0);
        take();
        do_op("mul_ovf", 4'd6, 8'd20, 8'd20, E_MUL20, 8);

        do_op("sll3", 4'd4, 8'h81, 8'd3, 8'h08, 3);
        do_op("sll0", 4'd4, 8'h81, 8'd0, 8'h81, 0);
        do_op("srl7", 4'd5, 8'h80, 8'd7, 8'h01, 7);
        do_op("srl4", 4'd5, 8'hF0, 8'd4, 8'h0F, 4);

        do_op("cmp_lt", 4'd8, 8'd5, 8'd9, 8'd0, 0);
        check("cmp_lt_eq", EQ, 0);
        check("cmp_lt_lt", LT, 1);
        do_op("add2", 4'd0, 8'd1, 8'd2, 8'd3, 0);
        check("add_keep_eq", EQ, 0);
        check("add_keep_lt", LT, 1);
        do_op("cmp_eq", 4'd8, 8'd9, 8'd9, 8'd0, 0);
        check("cmp_eq_eq", EQ, 1);
        check("cmp_eq_lt", LT, 0);

        do_op("sub", 4'd1, 8'd10, 8'd3, E_SUB, 0);
        do_op("add_wrap", 4'd0, 8'd200, 8'd100, E_ADD, 0);
        do_op("sb1", 4'd11, 8'h00, 8'd7, 8'h80, 0);
        do_op("sb0", 4'd10, 8'hFF, 8'd2, 8'hFB, 0);
        do_op("gbi", 4'd9, 8'h40, 8'd6, 8'h01, 0);
        do_op("xall", 4'd7, 8'h00, 8'h07, 8'h01, 0);
        do_op("and", 4'd2, 8'hCC, 8'hAA, 8'h88, 0);
        do_op("mv", 4'd12, 8'h5A, 8'h00, 8'h5A, 0);
        do_op("op14", 4'd14, 8'h12, 8'h34, 8'h00, 0);
        check("op14_eq", EQ, 1);

        run(4'd3, 8'h0F, 8'hF0, r, l, rs);
        check("xor", r, 8'hFF);
        OP = 4'd0; InputA = 8'd2; InputB = 8'd5; In_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out", Out, 8'hFF);
            check("stall_rdy", In_ready, 0);
            check("stall_vld", Out_valid, 1);
        end
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        check("pulse_vld", Out_valid, 0);
        check("pulse_hold", Out, 8'hFF);
        check("pulse_rdy", In_ready, 1);
        tick();
        In_valid = 1'b0;
        check("late_add", Out, 8'd7);
        check("late_vld", Out_valid, 1);
        take();

        OP = 4'd6; InputA = 8'd13; InputB = 8'd11; In_valid = 1'b1;
        tick();
        In_valid = 1'b0;
        tick(); tick(); tick();
        Reset_n = 1'b0;
        #2;
        check("mrst_out", Out, 0);
        check("mrst_vld", Out_valid, 0);
        check("mrst_eq", EQ, 0);
        check("mrst_lt", LT, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        check("mrst_rdy", In_ready, 1);
        do_op("add_after_rst", 4'd0, 8'd3, 8'd4, 8'd7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
